// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if: requester handshakes plus the shared APB bus of the arbiter
interface apb_arbiter_if #(parameter int AW = 16, parameter int DW = 16);
  logic          req0, write0, done0, err0;
  logic          req1, write1, done1, err1;
  logic [AW-1:0] addr0, addr1, paddr;
  logic [DW-1:0] wdata0, wdata1, rdata, pwdata, prdata;
  logic          pwrite, psel, penable, pready;
  modport master (
    input  req0, addr0, write0, wdata0, req1, addr1, write1, wdata1, prdata, pready,
    output done0, err0, done1, err1, rdata, paddr, pwrite, pwdata, psel, penable
  );
  modport slave (
    output req0, addr0, write0, wdata0, req1, addr1, write1, wdata1, prdata, pready,
    input  done0, err0, done1, err1, rdata, paddr, pwrite, pwdata, psel, penable
  );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin two-requester APB master with ACCESS-phase timeout
module apb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input logic clk,
  input logic reset,
  apb_arbiter_if.master bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic          done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
  logic          last_q, last_d;
  logic          e0, e1, pick, tmo;
  // a requester whose done pulse is still high must wait one cycle to re-arm
  assign e0 = bus.req0 & ~done0_q;
  assign e1 = bus.req1 & ~done1_q;
  assign pick = e0 & e1 ? ~last_q : e1;
  assign tmo = TIMEOUT != 0 && cnt_q == TMAX;
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d = rdata_q;
    psel_d = psel_q;
    penable_d = penable_q;
    cnt_d = cnt_q;
    last_d = last_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d = 1'b0;
    err1_d = 1'b0;
    case (state_q)
      IDLE: if (e0 | e1) begin
        last_d = pick;
        paddr_d = pick ? bus.addr1 : bus.addr0;
        pwrite_d = pick ? bus.write1 : bus.write0;
        pwdata_d = pick ? bus.wdata1 : bus.wdata0;
        psel_d = 1'b1;
        state_d = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d = '0;
        state_d = ACCESS;
      end
      ACCESS: if (bus.pready | tmo) begin
        rdata_d = pwrite_q ? rdata_q : bus.pready ? bus.prdata : '0;
        done0_d = ~last_q;
        done1_d = last_q;
        err0_d = ~bus.pready & ~last_q;
        err1_d = ~bus.pready & last_q;
        psel_d = 1'b0;
        penable_d = 1'b0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q <= '0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      cnt_q <= '0;
      last_q <= 1'b1;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q <= rdata_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end
  assign bus.paddr = paddr_q;
  assign bus.pwrite = pwrite_q;
  assign bus.pwdata = pwdata_q;
  assign bus.rdata = rdata_q;
  assign bus.psel = psel_q;
  assign bus.penable = penable_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.err0 = err0_q;
  assign bus.err1 = err1_q;
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
Two-requester APB master front-end that shares the single 16-bit APB bus between the CPU and a second bus master (DMA/SPI loader). Arbitrates round-robin, sequences APB SETUP/ACCESS phases, and returns read data and completion status to the granted requester. Its psel output feeds the system address decoder in place of a direct CPU select. An ACCESS-phase timeout keeps a stalled slave from hanging the bus.

Parameters:
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; 0 disables the timeout.
AW, 16, address width.
DW, 16, data width.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 (CPU) transfer request; level, held until done0
addr0  in  AW  requester 0 address
write0  in  1  requester 0 direction, 1=write
wdata0  in  DW  requester 0 write data
done0  out  1  one-cycle pulse: requester 0 transfer finished
err0  out  1  one-cycle pulse with done0: transfer aborted by timeout
req1/addr1/write1/wdata1  in  1/AW/1/DW  requester 1, same semantics
done1/err1  out  1/1  requester 1, same semantics
rdata  out  DW  read data of the last completed read; shared by both requesters
paddr  out  AW  APB address
pwrite  out  1  APB direction
pwdata  out  DW  APB write data
psel  out  1  APB select, to the address decoder
penable  out  1  APB enable
prdata  in  DW  APB read data
pready  in  1  APB ready

Behaviour:
- Reset: state=IDLE; psel, penable, pwrite, paddr, pwdata, rdata, done0/1, err0/1 = 0; last_grant=1, so requester 0 wins the first tie; timeout counter=0.
- Registered states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: psel=0, penable=0; paddr/pwrite/pwdata hold their last values.
  - With only one eligible req: grant it.
  - With both eligible: grant the requester != last_grant.
  - On grant, latch addrX/writeX/wdataX into paddr/pwrite/pwdata, set grant and last_grant, go to SETUP.
- Eligibility: a requester whose done pulse is high in the current cycle is not eligible that cycle. Its next transaction is granted no earlier than the following cycle. The other requester may be granted in the done cycle.
- SETUP: exactly one cycle; psel=1, penable=0; always go to ACCESS. Clear the timeout counter.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable.
  - pready=1 at a clock edge:
    - read: rdata<=prdata;
    - doneX<=1 for the granted requester;
    - psel, penable<=0;
    - go to IDLE.
  - pready=0: increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with pready still 0:
    - abort: doneX<=1, errX<=1;
    - rdata<=0 if read, unchanged if write;
    - psel, penable<=0; go to IDLE.
  - pready=1 on the same edge as the timeout: normal completion wins, no err.
- Latency with zero wait states: req sampled in IDLE at cycle N; SETUP at N+1; ACCESS at N+2; done and rdata valid at N+3. Each pready=0 cycle adds one.
- Requester inputs are sampled only at grant. Changes after grant are ignored until done.
- done0 and done1 are never high in the same cycle. err is never high without done.
- Reset mid-transfer: the next edge forces IDLE and deasserts psel/penable. No done/err is issued for the aborted transfer.
- No back-to-back SETUP: at least one IDLE cycle with psel=0 between transfers.

Test Plan:
- Single read: req0=1, addr0=16'h4010, write0=0; slave pready=1 first ACCESS cycle, prdata=16'hBEEF -> psel at N+1, penable at N+2, done0 pulse at N+3, rdata=16'hBEEF, err0=0.
- Wait states and write: req1 writes wdata1=16'h1234 to 16'h8004; pready low 3 cycles -> paddr/pwdata stable throughout ACCESS; done1 at N+6; no done0.
- Contention fairness: req0 and req1 both held high continuously for 4 transfers -> grant order 0,1,0,1; each done pulse one cycle; IDLE gap (psel=0) between transfers.
- Timeout: TIMEOUT=16, read to 16'hC000, pready never asserted -> abort after 16 ACCESS cycles; done0=err0=1 for one cycle; rdata=0; psel=0 next cycle. Also pready=1 exactly at the timeout edge -> done0=1, err0=0.
- Reset in ACCESS: assert reset during wait state -> next cycle psel=penable=0, state IDLE, no done/err; a fresh req0 after reset is granted normally.
- Re-arm rule: req0 held high through done0 with new addr0 -> no grant in the done cycle; grant on the following cycle with the new address.
